// File: rtl/jelly_tick_scheduler_pkg.sv
// Shared types for the tick scheduler: timestamp/channel types and per-channel state.
package jelly_tick_scheduler_pkg;

    localparam int unsigned TIME_W   = 32;
    localparam int unsigned MAX_CH_W = 4;

    typedef logic [TIME_W-1:0]   time_t;
    typedef logic [MAX_CH_W-1:0] ch_t;

    typedef struct packed {
        logic  enable;
        logic  pending;
        time_t period;
        time_t deadline;
        time_t ts;
    } ch_state_t;

    localparam ch_state_t CH_STATE_RESET = '0;

endpackage

// File: rtl/jelly_rr_pick.sv
// Combinational round-robin pick: first set request at index >= base, wrapping.
module jelly_rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned CH_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [CH_W-1:0] base,
    output logic [CH_W-1:0] grant,
    output logic            any
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    int unsigned    idx;

    // Rotate so that position 0 of req_rot corresponds to the base channel.
    assign req_dbl = {req, req} >> base;
    assign req_rot = req_dbl[N-1:0];

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!any && req_rot[k]) begin
                any = 1'b1;
                idx = 32'(base) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                grant = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/jelly_tick_scheduler.sv
// Free-running cycle counter shared by N periodic event channels; pending events are
// serialised onto one valid/ready stream with round-robin arbitration.
module jelly_tick_scheduler
    import jelly_tick_scheduler_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned CH_W = (N > 1) ? $clog2(N) : 1,
    parameter int unsigned TW   = TIME_W
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            cfg_we,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic            cfg_enable,
    input  logic [TW-1:0]   cfg_phase,
    input  logic [TW-1:0]   cfg_period,

    output logic [TW-1:0]   counter,

    output logic            m_valid,
    input  logic            m_ready,
    output logic [CH_W-1:0] m_ch,
    output logic [TW-1:0]   m_timestamp,

    output logic [N-1:0]    overrun
);

    time_t           counter_q;
    ch_state_t       ch_q [N];
    ch_state_t       ch_d [N];
    logic [N-1:0]    overrun_q;
    logic [N-1:0]    overrun_d;

    logic            m_valid_q;
    logic [CH_W-1:0] m_ch_q;
    time_t           m_ts_q;
    logic [CH_W-1:0] rr_q;

    logic [N-1:0]    pending;
    logic [N-1:0]    fire;
    logic [N-1:0]    grant_vec;
    logic [CH_W-1:0] sel;
    logic            sel_any;
    time_t           sel_ts;
    logic [CH_W-1:0] rr_next;
    logic            out_load;

    time_t           cfg_phase_t;
    time_t           cfg_period_t;
    time_t           cfg_deadline;

    assign cfg_phase_t  = time_t'(cfg_phase);
    assign cfg_period_t = time_t'(cfg_period);
    assign cfg_deadline = counter_q + cfg_phase_t + time_t'(1);

    always_comb begin
        pending = '0;
        fire    = '0;
        for (int i = 0; i < N; i++) begin
            pending[i] = ch_q[i].pending;
            fire[i]    = ch_q[i].enable && (counter_q == ch_q[i].deadline);
        end
    end

    jelly_rr_pick #(
        .N    (N),
        .CH_W (CH_W)
    ) u_pick (
        .req   (pending),
        .base  (rr_q),
        .grant (sel),
        .any   (sel_any)
    );

    assign out_load = !m_valid_q || m_ready;
    assign rr_next  = (sel == CH_W'(N - 1)) ? '0 : sel + CH_W'(1);

    always_comb begin
        grant_vec = '0;
        sel_ts    = '0;
        for (int i = 0; i < N; i++) begin
            grant_vec[i] = out_load && sel_any && (sel == CH_W'(i));
            if (sel == CH_W'(i)) begin
                sel_ts = ch_q[i].ts;
            end
        end
    end

    // A config write wins over a fire on the same channel; a fire beats a grant.
    always_comb begin
        overrun_d = overrun_q;
        for (int i = 0; i < N; i++) begin
            ch_d[i] = ch_q[i];
            if (cfg_we && (ch_t'(cfg_ch) == ch_t'(i))) begin
                ch_d[i].enable   = cfg_enable;
                ch_d[i].period   = cfg_period_t;
                ch_d[i].deadline = cfg_deadline;
                ch_d[i].pending  = 1'b0;
                overrun_d[i]     = 1'b0;
            end else begin
                if (grant_vec[i]) begin
                    ch_d[i].pending = 1'b0;
                end
                if (fire[i]) begin
                    ch_d[i].pending = 1'b1;
                    ch_d[i].ts      = counter_q;
                    if (ch_q[i].period != '0) begin
                        ch_d[i].deadline = counter_q + ch_q[i].period;
                    end else begin
                        ch_d[i].enable = 1'b0;
                    end
                    if (ch_q[i].pending && !grant_vec[i]) begin
                        overrun_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter_q <= '0;
            overrun_q <= '0;
            for (int i = 0; i < N; i++) begin
                ch_q[i] <= CH_STATE_RESET;
            end
        end else begin
            counter_q <= counter_q + time_t'(1);
            overrun_q <= overrun_d;
            for (int i = 0; i < N; i++) begin
                ch_q[i] <= ch_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_ch_q    <= '0;
            m_ts_q    <= '0;
            rr_q      <= '0;
        end else if (out_load) begin
            m_valid_q <= sel_any;
            if (sel_any) begin
                m_ch_q <= sel;
                m_ts_q <= sel_ts;
                rr_q   <= rr_next;
            end
        end
    end

    assign counter     = TW'(counter_q);
    assign m_valid     = m_valid_q;
    assign m_ch        = m_ch_q;
    assign m_timestamp = TW'(m_ts_q);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_jelly_tick_scheduler.sv
// Self-checking bench for jelly_tick_scheduler: table-driven single-channel scenarios plus
// hand-written arbitration, overrun and counter-wrap sequences, checked via an event scoreboard.
module tb_jelly_tick_scheduler;

    localparam int N    = 4;
    localparam int CH_W = 2;
    localparam int TW   = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cfg_we = 1'b0;
    logic [CH_W-1:0] cfg_ch = '0;
    logic            cfg_enable = 1'b0;
    logic [TW-1:0]   cfg_phase = '0;
    logic [TW-1:0]   cfg_period = '0;
    logic [TW-1:0]   counter;
    logic            m_valid;
    logic            m_ready = 1'b1;
    logic [CH_W-1:0] m_ch;
    logic [TW-1:0]   m_timestamp;
    logic [N-1:0]    overrun;

    jelly_tick_scheduler #(
        .N    (N),
        .CH_W (CH_W),
        .TW   (TW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_enable  (cfg_enable),
        .cfg_phase   (cfg_phase),
        .cfg_period  (cfg_period),
        .counter     (counter),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_ch        (m_ch),
        .m_timestamp (m_timestamp),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH_W-1:0] ch;
        logic [TW-1:0]   ts;
    } ev_t;

    typedef struct {
        logic [CH_W-1:0] ch;
        logic [TW-1:0]   at;
        logic [TW-1:0]   phase;
        logic [TW-1:0]   period;
        logic [TW-1:0]   stop_at;
        int              n_ev;
        logic [TW-1:0]   first_ts;
        logic [TW-1:0]   step;
        logic [TW-1:0]   first_valid;
        int              idle;
    } vec_t;

    ev_t  exp_q[$];
    vec_t vecs[4];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Transfer happens on the posedge after a negedge that sees valid && ready.
    always @(negedge clk) begin
        if (!reset && m_valid && m_ready) begin
            ev_t e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL event_unexpected: got ch=%0d ts=%0h want no event", m_ch, m_timestamp);
            end else begin
                e = exp_q.pop_front();
                if (m_ch !== e.ch || m_timestamp !== e.ts) begin
                    failures++;
                    $display("FAIL event: got ch=%0d ts=%0h want ch=%0d ts=%0h",
                             m_ch, m_timestamp, e.ch, e.ts);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset  = 1'b1;
        cfg_we = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_counter(input logic [TW-1:0] c);
        int n = 0;
        while (counter !== c && n < 2000) begin
            tick();
            n++;
        end
        if (counter !== c) begin
            checks++;
            failures++;
            $display("FAIL wait_counter: got %0h want %0h", counter, c);
        end
    endtask

    task automatic cfg_write(input logic [CH_W-1:0] ch, input logic en,
                             input logic [TW-1:0] phase, input logic [TW-1:0] period);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_enable = en;
        cfg_phase  = phase;
        cfg_period = period;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_valid(output logic [TW-1:0] at);
        int n = 0;
        while (!m_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!m_valid) begin
            checks++;
            failures++;
            $display("FAIL wait_valid: got m_valid=0 want 1 within 500 cycles");
        end
        at = counter;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_pending_events", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        logic [TW-1:0] t;

        vecs[0] = '{ch: 2'd0, at: 20, phase: 4, period: 10, stop_at: 50, n_ev: 3,
                    first_ts: 25, step: 10, first_valid: 27, idle: 40};
        vecs[1] = '{ch: 2'd1, at: 50, phase: 0, period: 0, stop_at: 0, n_ev: 1,
                    first_ts: 51, step: 0, first_valid: 53, idle: 260};
        vecs[2] = '{ch: 2'd2, at: 7, phase: 3, period: 1, stop_at: 16, n_ev: 5,
                    first_ts: 11, step: 1, first_valid: 13, idle: 40};
        vecs[3] = '{ch: 2'd3, at: 3, phase: 0, period: 7, stop_at: 30, n_ev: 4,
                    first_ts: 4, step: 7, first_valid: 6, idle: 40};

        // Reset state and idle counting.
        tick();
        tick();
        check("reset_counter", 64'(counter), 64'd0);
        check("reset_m_valid", 64'(m_valid), 64'd0);
        check("reset_m_ch", 64'(m_ch), 64'd0);
        check("reset_m_timestamp", 64'(m_timestamp), 64'd0);
        check("reset_overrun", 64'(overrun), 64'd0);
        reset = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            check("idle_counter_valid_overrun", {27'd0, counter, m_valid, overrun},
                  {27'd0, TW'(k), 1'b0, 4'b0000});
        end

        // Table of single-channel scenarios.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            m_ready = 1'b1;
            wait_counter(vecs[v].at);
            for (int k = 0; k < vecs[v].n_ev; k++) begin
                exp_q.push_back('{ch: vecs[v].ch,
                                  ts: vecs[v].first_ts + TW'(k) * vecs[v].step});
            end
            cfg_write(vecs[v].ch, 1'b1, vecs[v].phase, vecs[v].period);
            wait_valid(t);
            check($sformatf("vec%0d_first_valid_counter", v), 64'(t), 64'(vecs[v].first_valid));
            if (vecs[v].stop_at != 0) begin
                wait_counter(vecs[v].stop_at);
                cfg_write(vecs[v].ch, 1'b0, '0, '0);
            end
            repeat (vecs[v].idle) tick();
            check($sformatf("vec%0d_events_left", v), 64'(exp_q.size()), 64'd0);
            check($sformatf("vec%0d_overrun", v), 64'(overrun), 64'd0);
        end

        // Aligned channels at deadline 100; ch0 period 9 puts ch0 behind ch2 in round two.
        do_reset();
        m_ready = 1'b1;
        wait_counter(90);
        cfg_write(2'd0, 1'b1, 9, 9);
        wait_counter(91);
        cfg_write(2'd1, 1'b1, 8, 8);
        wait_counter(92);
        cfg_write(2'd2, 1'b1, 7, 8);
        exp_q.push_back('{ch: 2'd0, ts: 100});
        exp_q.push_back('{ch: 2'd1, ts: 100});
        exp_q.push_back('{ch: 2'd2, ts: 100});
        exp_q.push_back('{ch: 2'd1, ts: 108});
        exp_q.push_back('{ch: 2'd2, ts: 108});
        exp_q.push_back('{ch: 2'd0, ts: 109});
        for (int k = 0; k < 3; k++) begin
            wait_counter(TW'(102 + k));
            check($sformatf("rr_back_to_back_%0d", k), {61'd0, m_valid, m_ch}, {61'd0, 1'b1, 2'(k)});
        end
        wait_counter(112);
        cfg_write(2'd0, 1'b0, '0, '0);
        cfg_write(2'd1, 1'b0, '0, '0);
        cfg_write(2'd2, 1'b0, '0, '0);
        wait_drain(20);
        repeat (30) tick();

        // Backpressure on ch3 period 2: hold, sticky overrun, latest timestamp, cfg clear.
        do_reset();
        m_ready = 1'b0;
        wait_counter(5);
        cfg_write(2'd3, 1'b1, 0, 2);
        exp_q.push_back('{ch: 2'd3, ts: 6});
        exp_q.push_back('{ch: 2'd3, ts: 16});
        exp_q.push_back('{ch: 2'd3, ts: 18});
        exp_q.push_back('{ch: 2'd3, ts: 20});
        for (int c = 8; c < 18; c++) begin
            wait_counter(TW'(c));
            check("hold_stable", {29'd0, m_valid, m_ch, m_timestamp}, {29'd0, 1'b1, 2'd3, 32'd6});
            if (c == 10) check("overrun_not_yet", 64'(overrun), 64'h0);
            if (c == 11) check("overrun_set", 64'(overrun), 64'h8);
        end
        wait_counter(18);
        m_ready = 1'b1;
        wait_counter(19);
        check("overrun_sticky", 64'(overrun), 64'h8);
        wait_counter(21);
        cfg_write(2'd3, 1'b0, '0, '0);
        check("overrun_cleared_by_cfg", 64'(overrun), 64'h0);
        wait_drain(20);
        repeat (20) tick();

        // Counter wrap, then reset while an event is held.
        do_reset();
        m_ready = 1'b1;
        wait_counter(0);
        cfg_write(2'd0, 1'b1, 32'hFFFF_FFF0, 32'h20);
        force dut.counter_q = 32'hFFFF_FFE0;
        @(negedge clk);
        release dut.counter_q;
        tick();
        check("counter_jump", 64'(counter), 64'hFFFF_FFE1);
        exp_q.push_back('{ch: 2'd0, ts: 32'hFFFF_FFF1});
        exp_q.push_back('{ch: 2'd0, ts: 32'h0000_0011});
        wait_drain(100);
        m_ready = 1'b0;
        wait_counter(32'h33);
        check("wrap_held_event", {29'd0, m_valid, m_ch, m_timestamp}, {29'd0, 1'b1, 2'd0, 32'h31});
        reset = 1'b1;
        tick();
        check("midreset_counter", 64'(counter), 64'd0);
        check("midreset_m_valid", 64'(m_valid), 64'd0);
        check("midreset_overrun", 64'(overrun), 64'd0);
        tick();
        reset = 1'b0;
        m_ready = 1'b1;
        repeat (100) tick();

        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jelly_tick_scheduler.md
Name: jelly_tick_scheduler

Overview:
- Owns the free-running 32-bit cycle counter and shares it between N periodic event channels.
- Each channel holds a programmable phase and period, and raises an event whenever the counter reaches its deadline.
- Pending events are serialised onto one valid/ready output stream by round-robin arbitration.
- Sits beside the testbench/system counter as the sequencer that turns raw time into scheduled stimulus or trigger events.

Parameters:
- N, 4, number of channels (1..16).
- CH_W, $clog2(N) min 1, channel index width.
- TW, 32, counter/timestamp/period width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  CH_W  channel being configured
- cfg_enable  in  1  channel enable
- cfg_phase  in  TW  delay to first event
- cfg_period  in  TW  event period; 0 = one-shot
- counter  out  TW  current cycle counter
- m_valid  out  1  event available
- m_ready  in  1  consumer accepts event
- m_ch  out  CH_W  channel of event
- m_timestamp  out  TW  counter value at which the event fired
- overrun  out  N  sticky per-channel missed-event flags

Behaviour:
- Reset: counter=0, m_valid=0, m_ch=0, m_timestamp=0, overrun=0, all enables/pending=0, rr pointer=0, deadlines/periods=0.
- Counter: increments by 1 every non-reset cycle; wraps 2^TW-1 -> 0 with no flag.
- cfg write in the cycle where counter==C:
  - enable <= cfg_enable; period <= cfg_period; deadline <= C+cfg_phase+1 (mod 2^TW).
  - pending[ch] <= 0; overrun[ch] <= 0.
  - Out-of-range cfg_ch (>=N) is ignored.
- Fire condition: enable[i] && counter==deadline[i]. In that cycle, with T=counter:
  - pending[i]<=1; ts[i]<=T.
  - If period!=0: deadline<=T+period (mod, wrap-safe equality compare). If period==0: enable<=0.
  - If pending[i] is already 1 and not being granted this cycle: overrun[i]<=1; ts[i] takes the newest T.
- Same-cycle priority:
  - cfg write to channel i overrides a fire of channel i.
  - A fire and a grant on the same channel leave pending=1 with the new ts and set no overrun.
- Output stage (registered):
  - Load when !m_valid || m_ready.
  - Pick the first pending channel at index >= rr, wrapping; the pick uses registered pending state.
  - m_valid<=1; m_ch<=sel; m_timestamp<=ts[sel]; clear pending[sel]; rr<=sel+1 mod N.
  - If nothing is pending, m_valid<=0.
- Handshake: m_valid/m_ch/m_timestamp hold stable while m_valid && !m_ready. Back-to-back transfers sustain 1 event/cycle.
- Latency: fire at counter T -> pending at T+1 -> m_valid visible at cycle T+2 at earliest (counter reads T+2).
- Reset mid-operation returns everything to reset values in one cycle; in-flight events are lost.

Decomposition:
- Package jelly_tick_scheduler_pkg holds:
  - time_t (logic [TW-1:0]);
  - ch_t;
  - a channel-state struct {enable, pending, period, deadline, ts}.
- Sub-module jelly_rr_pick: combinational N-wide round-robin priority pick (req, base pointer -> grant index, any).

Test Plan:
- Reset then idle -> counter reads 0,1,2,...; m_valid stays 0 and overrun=0 for 100 cycles.
- cfg ch0 enable=1, phase=4, period=10 written at counter=20 -> events with m_timestamp 25,35,45; m_valid first at counter=27; m_ready held 1.
- ch1 one-shot (period=0, phase=0) written at counter=50 -> exactly one event, timestamp 51; enable reads back off; no further events over 2^8 cycles.
- ch0,ch1,ch2 all with phase=9, period=8, written at same base (three writes, phases adjusted to align, deadline=100) -> three events at timestamp 100 output in order 0,1,2 on consecutive cycles; next round starts from rr continuation.
- ch3 period=2 with m_ready=0 for 10 cycles -> m_valid held stable, overrun[3]=1 sticky; after m_ready=1, latest timestamp delivered; cfg rewrite of ch3 clears overrun[3].
- Force counter near wrap (phase=0xFFFF_FFF0 written at counter 0, period=0x20) -> fires at 0xFFFF_FFF1, then 0x0000_0011; assert reset mid-stream -> m_valid=0, counter=0 next cycle.
